// File: rtl/serial_pkg.sv
// Shared types and line constants for the serial transmit/receive pair.
// Kept in one package so both ends agree on the line encoding.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Counter width for a modulus n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter; tick marks the last clock of each serial bit.
// Shared by the transmitter and the matching receiver.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int TW = cnt_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - TW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start, data, optional parity, stop bits.
// All outputs are registered; next values come from one comb process.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int LSB_FIRST    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int IW = cnt_w(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD = 1'(PARITY_ODD);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [IW-1:0]    idx, idx_n;
  logic             par, par_n;
  logic             stop_cnt, stop_cnt_n;
  logic             ser_n, busy_n, rdy_n, done_n;
  logic             accept, tick;

  function automatic logic out_bit(input logic [WIDTH-1:0] s);
    return (LSB_FIRST != 0) ? s[0] : s[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] s);
    return (LSB_FIRST != 0) ? (s >> 1) : (s << 1);
  endfunction

  assign accept = (state == IDLE) && in_valid && in_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      par      <= 1'b0;
      stop_cnt <= 1'b0;
      ser_out  <= LINE_IDLE;
      busy     <= 1'b0;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      idx      <= idx_n;
      par      <= par_n;
      stop_cnt <= stop_cnt_n;
      ser_out  <= ser_n;
      busy     <= busy_n;
      in_ready <= rdy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    idx_n      = idx;
    par_n      = par;
    stop_cnt_n = stop_cnt;
    ser_n      = ser_out;
    busy_n     = busy;
    rdy_n      = in_ready;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          shreg_n = in_data;
          par_n   = (^in_data) ^ ODD;
          ser_n   = LINE_START;
          busy_n  = 1'b1;
          rdy_n   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
          ser_n   = out_bit(shreg);
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            stop_cnt_n = 1'b0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              ser_n   = par;
            end else begin
              state_n = STOP;
              ser_n   = LINE_IDLE;
            end
          end else begin
            idx_n   = idx + IW'(1);
            shreg_n = shift(shreg);
            ser_n   = out_bit(shift(shreg));
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n    = STOP;
          stop_cnt_n = 1'b0;
          ser_n      = LINE_IDLE;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            rdy_n   = 1'b1;
            done_n  = 1'b1;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        ser_n   = LINE_IDLE;
        busy_n  = 1'b0;
        rdy_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: five configurations checked against a frame model.
// Directed vectors add literal expectations on top of the model compare.
module tb_serial_tx;

  localparam int NI = 5;
  localparam int P_W  [NI] = '{8, 8, 8, 8, 1};
  localparam int P_C  [NI] = '{4, 2, 2, 1, 1};
  localparam int P_L  [NI] = '{1, 0, 0, 1, 1};
  localparam int P_PE [NI] = '{0, 1, 1, 0, 0};
  localparam int P_PO [NI] = '{0, 0, 1, 0, 0};
  localparam int P_S  [NI] = '{1, 1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vld [NI];
  logic [7:0] dat [NI];
  logic       ser [NI];
  logic       bsy [NI];
  logic       rdy [NI];
  logic       dn  [NI];

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;
  int dcnt [NI];

  int         m_pos  [NI];
  logic [7:0] m_dat  [NI];
  logic       m_done [NI];

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .in_data(dat[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(2), .LSB_FIRST(0),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .in_data(dat[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(2), .LSB_FIRST(0),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .in_data(dat[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .in_data(dat[3]), .in_valid(vld[3]),
    .in_ready(rdy[3]), .ser_out(ser[3]), .busy(bsy[3]), .done(dn[3]));

  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1), .LSB_FIRST(1),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u4 (
    .clk(clk), .reset(reset), .in_data(dat[4][0:0]), .in_valid(vld[4]),
    .in_ready(rdy[4]), .ser_out(ser[4]), .busy(bsy[4]), .done(dn[4]));

  function automatic int frame_len(input int i);
    return P_C[i] * (1 + P_W[i] + P_PE[i] + P_S[i]);
  endfunction

  // Line level pos clocks after the accept edge, from the frame rules.
  function automatic logic exp_bit(input int i, input int pos);
    int b;
    logic p;
    logic [7:0] d;
    d = m_dat[i];
    b = pos / P_C[i];
    if (b == 0) return 1'b0;
    b = b - 1;
    if (b < P_W[i]) return (P_L[i] != 0) ? d[b] : d[P_W[i] - 1 - b];
    b = b - P_W[i];
    if (P_PE[i] != 0 && b == 0) begin
      p = (P_PO[i] != 0);
      for (int j = 0; j < P_W[i]; j++) p = p ^ d[j];
      return p;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        m_pos[i]  = -1;
        m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_pos[i] >= 0) begin
          m_pos[i] = m_pos[i] + 1;
          if (m_pos[i] == frame_len(i)) begin
            m_pos[i]  = -1;
            m_done[i] = 1'b1;
          end
        end else if (vld[i]) begin
          m_pos[i] = 0;
          m_dat[i] = dat[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%b want=%b", nm, i, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (dn[i] === 1'b1) dcnt[i]++;
      if (run_chk) begin
        chk("m_ser", i, ser[i], (m_pos[i] < 0) ? 1'b1 : exp_bit(i, m_pos[i]));
        chk("m_busy", i, bsy[i], m_pos[i] >= 0);
        chk("m_ready", i, rdy[i], m_pos[i] < 0);
        chk("m_done", i, dn[i], m_done[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d);
    vld[i] = 1'b1;
    dat[i] = d;
    tick();
    vld[i] = 1'b0;
    dat[i] = 8'($urandom);
  endtask

  logic lit_a [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int d0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      vld[i]  = 1'b0;
      dat[i]  = 8'h00;
      dcnt[i] = 0;
    end
    repeat (2) tick();
    for (int i = 0; i < NI; i++) begin
      chk("rst_ser", i, ser[i], 1'b1);
      chk("rst_busy", i, bsy[i], 1'b0);
      chk("rst_ready", i, rdy[i], 1'b1);
      chk("rst_done", i, dn[i], 1'b0);
    end
    reset = 1'b1;
    run_chk = 1'b1;
    tick();

    // 0xA5, LSB first, CPB=4, with an ignored request mid-frame
    d0 = dcnt[0];
    send(0, 8'hA5);
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 2) chk("a5_bit", 0, ser[0], lit_a[c / 4]);
      if (c == 10) begin
        vld[0] = 1'b1;
        dat[0] = 8'h55;
      end
      if (c == 11) vld[0] = 1'b0;
      tick();
    end
    chk("a5_done40", 0, dn[0], 1'b1);
    chk("a5_ready40", 0, rdy[0], 1'b1);
    repeat (45) tick();
    chk_int("a5_one_done", dcnt[0] - d0, 1);

    // Reset mid-frame, then a clean 0x00 frame
    send(0, 8'hFF);
    repeat (9) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_ser", 0, ser[0], 1'b1);
    chk("arst_busy", 0, bsy[0], 1'b0);
    chk("arst_ready", 0, rdy[0], 1'b1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    send(0, 8'h00);
    repeat (39) tick();
    chk("zero_last_stop", 0, ser[0], 1'b1);
    tick();
    chk("zero_done", 0, dn[0], 1'b1);
    tick();

    // MSB first with even then odd parity
    send(1, 8'hA5);
    for (int c = 0; c < 22; c++) begin
      if (c == 2) chk("b_msb", 1, ser[1], 1'b1);
      if (c == 4) chk("b_bit6", 1, ser[1], 1'b0);
      if (c == 18) chk("b_par_even", 1, ser[1], 1'b0);
      tick();
    end
    chk("b_done22", 1, dn[1], 1'b1);
    send(2, 8'hA5);
    for (int c = 0; c < 22; c++) begin
      if (c == 18) chk("c_par_odd", 2, ser[2], 1'b1);
      tick();
    end
    chk("c_done22", 2, dn[2], 1'b1);

    // Back-to-back, two stop bits, CPB=1
    vld[3] = 1'b1;
    dat[3] = 8'h3C;
    tick();
    dat[3] = 8'hC3;
    repeat (11) tick();
    chk("d_done1", 3, dn[3], 1'b1);
    chk("d_idle_hi", 3, ser[3], 1'b1);
    tick();
    chk("d_start2", 3, ser[3], 1'b0);
    chk("d_busy2", 3, bsy[3], 1'b1);
    vld[3] = 1'b0;
    repeat (11) tick();
    chk("d_done2", 3, dn[3], 1'b1);
    tick();

    // Single-bit word
    send(4, 8'h01);
    chk("e_start", 4, ser[4], 1'b0);
    tick();
    chk("e_data", 4, ser[4], 1'b1);
    tick();
    chk("e_stop", 4, ser[4], 1'b1);
    tick();
    chk("e_done", 4, dn[4], 1'b1);
    repeat (4) tick();

    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter that takes a WIDTH-bit word over a valid/ready handshake and drives it onto a single-bit line.
- Frame format: start bit, data bits, optional parity bit, stop bit(s). Each bit is held for CLKS_PER_BIT clocks.
- This is the driving end of the single-bit serial links our flop-based receive/capture logic samples.
- Sits between a parallel source (register block or FIFO read side) and a single output pin or wire.

Parameters:
- WIDTH, 8: data bits per frame (>=1).
- CLKS_PER_BIT, 16: clock cycles per serial bit (>=1).
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  word to transmit; sampled at handshake.
- in_valid  in  1  source has a word.
- in_ready  out  1  block can accept a word.
- ser_out  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ser_out=1, in_ready=1, busy=0, done=0, shift register and counters cleared. An in-progress frame is abandoned immediately; the line returns high with no stop bit.
- All outputs are registered; no combinational path from inputs to outputs.
- Handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1. in_ready=1 only in IDLE. in_valid while busy is ignored (no overflow, no error). in_data is don't-care outside the handshake edge.
- On the accept edge: in_data is captured into the shift register; parity is computed and stored (even: XOR of the data; odd: its inverse); state becomes START, ser_out=0, busy=1, in_ready=0.
- States:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: WIDTH bits, each held CLKS_PER_BIT cycles, in the order set by LSB_FIRST. After the last bit, go to PARITY if PARITY_EN=1, otherwise STOP.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP: ser_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Frame length: N = CLKS_PER_BIT*(1+WIDTH+PARITY_EN+STOP_BITS) cycles, counted from the accept edge to the edge that re-enters IDLE.
- On the re-entry edge: busy=0, in_ready=1, done=1 for exactly one cycle.
- Back-to-back: with in_valid held high, the next accept happens on the edge after re-entry. Frames are therefore separated by exactly one idle-high clock cycle.
- Bit timer: down-counter of width $clog2(CLKS_PER_BIT), minimum 1. Reloaded to CLKS_PER_BIT-1 on every bit boundary. CLKS_PER_BIT=1 must work, giving one cycle per bit.
- Bit index counter: width $clog2(WIDTH), minimum 1. Wraps only by leaving DATA, never by overflow.
- Shift register shifts by one position on each data-bit boundary. ser_out is taken from bit 0 or bit WIDTH-1 according to LSB_FIRST.

Decomposition:
- Package serial_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constants LINE_IDLE=1'b1 and LINE_START=1'b0, shared with the matching receiver.
- Sub-module bit_timer (parameter CLKS_PER_BIT): ports clk, reset, restart, tick.
  - tick is a one-cycle pulse on the last cycle of each bit period.
  - restart forces a reload.
  - The receiver will reuse this module.

Test Plan:
- Reset mid-frame: accept 0xFF, assert reset=0 at cycle 10 -> ser_out=1, busy=0, in_ready=1 immediately, with no clock edge required. After release, accepting 0x00 produces a clean frame.
- Basic frame, defaults with CLKS_PER_BIT=4: send 0xA5 -> ser_out=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. done pulses on cycle 40 after accept, and in_ready is 1 in that same cycle.
- Parity and MSB first (PARITY_EN=1, PARITY_ODD=0, LSB_FIRST=0, CLKS_PER_BIT=2): send 0xA5 -> data bits 1,0,1,0,0,1,0,1 (MSB first), parity 0, frame length 22 cycles. With PARITY_ODD=1 the parity bit is 1.
- Back-to-back (STOP_BITS=2, CLKS_PER_BIT=1): hold in_valid with 0x3C then 0xC3 -> frames of 11 cycles each, exactly one idle-high cycle between them, two done pulses 12 cycles apart.
- Ignored request: pulse in_valid with 0x55 while busy -> current frame unchanged, no extra frame sent, done pulses once.
- Minimal width (WIDTH=1, CLKS_PER_BIT=1): send 1'b1 -> ser_out sequence 0,1,1, then done.
